tlc_light_slave: RTL and testbench
==================================

Name: tlc_light_slave

Overview:
- Light-sequencing end of the traffic-light controller handshake.
- Consumes the master's 2-bit direction request `dir` and drives the per-approach lamp outputs through green → yellow → all-red → green.
- Returns `ok` to the master when the current green has met its minimum duration and a new direction may be requested.
- Sits between the master FSM and the lamp drivers; the master only changes `dir` on a cycle where `ok` is high.

Parameters:
- TWIDTH, 4, width of the phase down-counter.
- GREEN_MIN, 4, minimum green cycles before `ok` asserts; legal range 1..2**TWIDTH-1.
- YEL_CYC, 3, yellow duration in cycles; legal range 1..2**TWIDTH-1.
- RED_CYC, 2, all-red clearance duration in cycles; legal range 1..2**TWIDTH-1.
- PED_CYC, 6, walk-phase duration in cycles; used only with TLC_PED_EN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- dir  input  2  requested direction: 2'b00 NS, 2'b01 EW, 2'b10 LT, 2'b11 invalid.
- ok  output  1  high = minimum green done, master may change `dir`.
- light_ns  output  3  NS lamps {red,yellow,green}, one-hot.
- light_ew  output  3  EW lamps {red,yellow,green}, one-hot.
- light_lt  output  3  left-turn lamps {red,yellow,green}, one-hot.

Behaviour:
- Registers:
  - state ∈ {GREEN, YELLOW, ALLRED}.
  - cur[1:0]: direction holding right-of-way.
  - cnt[TWIDTH-1:0].
- Reset (rst=0, asynchronous, takes effect immediately): state=GREEN, cur=NS, cnt=GREEN_MIN-1. Outputs during reset: ok=0, light_ns=3'b001, light_ew=light_lt=3'b100.
- A reset mid-sequence abandons the sequence immediately, with no yellow.
- Phase entry loads cnt=duration-1. Each cycle cnt decrements while nonzero and holds at 0. Each phase therefore lasts exactly its duration in cycles (minimum).
- GREEN:
  - If cnt==0 and dir∈{00,01,10} and dir≠cur: next state YELLOW, cnt=YEL_CYC-1.
  - Otherwise stay in GREEN.
  - dir==11 is ignored.
- YELLOW: when cnt==0 → ALLRED, cnt=RED_CYC-1. `dir` is ignored throughout yellow; the change cannot be cancelled.
- ALLRED: when cnt==0 → GREEN, cnt=GREEN_MIN-1, cur=dir sampled that cycle. If the sampled dir is 11, cur=NS.
- Returning to the same direction: if dir equals the old cur at the end of ALLRED, the full sequence still completes and cur is re-granted.
- ok = (state==GREEN) && (cnt==0). It is a decode of registers only, with no combinational path from dir. It first rises in the GREEN_MIN-th cycle of green, is low throughout YELLOW and ALLRED, and drops the cycle after a change is accepted.
- Lamps:
  - GREEN: approach cur shows 001; all others 100.
  - YELLOW: approach cur shows 010; all others 100.
  - ALLRED: all approaches 100.
  - Exactly one bit is set per approach in every cycle, and at most one approach is non-red.
- Invalid state encodings recover to GREEN/NS on the next clock.

Optional Feature:
- Macro: TLC_PED_EN.
- Enabled:
  - Adds input `ped_req` (1 bit) and output `walk` (1 bit).
  - ped_req=1 sets a sticky pending flag.
  - On ALLRED expiry with the flag set, ALLRED is extended by PED_CYC cycles with walk=1, the flag clears, and then GREEN is entered as normal.
  - A ped_req arriving during the walk extension sets the flag for the next cycle of the sequence.
  - walk=0 and the flag clears on reset.
- Disabled: neither port exists and ALLRED is always exactly RED_CYC cycles.

Test Plan:
1. Hold rst=0 → light_ns=001, light_ew=100, light_lt=100, ok=0. Release with dir=00 → ok=1 from the 4th cycle after release and stays high.
2. With ok=1, set dir=01 → next cycle light_ns=010 for 3 cycles, then all 100 for 2 cycles, then light_ew=001. ok=0 for 3 cycles of EW green, 1 on the 4th.
3. Set dir=10 one cycle into a new green → green holds for the full 4 cycles, then yellow; light_lt=001 after 3+2 cycles; ok never high in between.
4. Hold dir=11 during a settled green → no transition, ok stays 1. dir=11 at ALLRED expiry → light_ns=001.
5. Change dir back to cur during YELLOW → yellow and all-red still complete, and the same approach returns to 001.
6. Assert rst=0 mid-YELLOW on EW → same cycle light_ns=001, light_ew=100, ok=0. With TLC_PED_EN: ped_req pulse → walk=1 for 6 cycles inside all-red.

Source files
------------

// File: rtl/tlc_light_slave.sv
// -----------------------------------------------------------------------------
// tlc_light_slave
// Light-sequencing end of the traffic-light controller handshake. Follows the
// master's direction request and walks the lamps through
// green -> yellow -> all-red -> green, telling the master via `ok` when the
// current green has served its minimum time.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active low
//   dir[1:0]  in   requested direction: 00 NS, 01 EW, 10 LT, 11 invalid
//   ok        out  minimum green done, master may change dir
//   light_ns  out  NS lamps {red,yellow,green}, one-hot
//   light_ew  out  EW lamps {red,yellow,green}, one-hot
//   light_lt  out  left-turn lamps {red,yellow,green}, one-hot
//   ped_req   in   pedestrian request (TLC_PED_EN builds only)
//   walk      out  walk lamp, high during the walk extension (TLC_PED_EN only)
//
// Build option: define TLC_PED_EN to add the pedestrian walk extension of
// the all-red phase. Without it ALLRED always lasts exactly RED_CYC cycles.
// -----------------------------------------------------------------------------
module tlc_light_slave #(
  parameter int TWIDTH    = 4,
  parameter int GREEN_MIN = 4,
  parameter int YEL_CYC   = 3,
  parameter int RED_CYC   = 2,
  parameter int PED_CYC   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] dir,
`ifdef TLC_PED_EN
  input  logic       ped_req,
  output logic       walk,
`endif
  output logic       ok,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic [2:0] light_lt
);

  localparam int CNT_MAX = (1 << TWIDTH) - 1;

  // Reject durations that cannot be loaded into the phase counter.
  if (GREEN_MIN < 1 || GREEN_MIN > CNT_MAX || YEL_CYC < 1 || YEL_CYC > CNT_MAX ||
      RED_CYC < 1 || RED_CYC > CNT_MAX || PED_CYC < 1 || PED_CYC > CNT_MAX) begin : g_bad_param
    $error("tlc_light_slave: phase duration out of range for TWIDTH");
  end

  localparam logic [TWIDTH-1:0] GREEN_LD = TWIDTH'(GREEN_MIN - 1);
  localparam logic [TWIDTH-1:0] YEL_LD   = TWIDTH'(YEL_CYC - 1);
  localparam logic [TWIDTH-1:0] RED_LD   = TWIDTH'(RED_CYC - 1);
`ifdef TLC_PED_EN
  localparam logic [TWIDTH-1:0] PED_LD   = TWIDTH'(PED_CYC - 1);
`endif

  localparam logic [1:0] DIR_NS  = 2'b00;
  localparam logic [1:0] DIR_EW  = 2'b01;
  localparam logic [1:0] DIR_LT  = 2'b10;
  localparam logic [1:0] DIR_BAD = 2'b11;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

`ifdef TLC_PED_EN
  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10,
    ST_WALK   = 2'b11
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_GREEN  = 2'b00,
    ST_YELLOW = 2'b01,
    ST_ALLRED = 2'b10
  } state_t;
`endif

  state_t            state_r, state_s;
  logic [TWIDTH-1:0] cnt_r, cnt_s;
  logic [1:0]        cur_r, cur_s;
`ifdef TLC_PED_EN
  logic              pend_r, pend_s;
  logic              walk_entry_s;
`endif

  // Lamp pattern {ns,ew,lt} for a given phase and right-of-way holder.
  function automatic logic [8:0] lamps(input state_t st, input logic [1:0] c);
    logic [2:0] on_v;
    logic [8:0] res_v;
    case (st)
      ST_GREEN:  on_v = LAMP_G;
      ST_YELLOW: on_v = LAMP_Y;
      default:   on_v = LAMP_R;
    endcase
    res_v = {LAMP_R, LAMP_R, LAMP_R};
    case (c)
      DIR_NS:  res_v[8:6] = on_v;
      DIR_EW:  res_v[5:3] = on_v;
      DIR_LT:  res_v[2:0] = on_v;
      default: res_v = {LAMP_R, LAMP_R, LAMP_R};
    endcase
    return res_v;
  endfunction

  // Next-state, counter and right-of-way computation.
  always_comb begin
    state_s = state_r;
    cur_s   = cur_r;
    if (cnt_r != '0) begin
      cnt_s = cnt_r - TWIDTH'(1);
    end else begin
      cnt_s = cnt_r;
    end
`ifdef TLC_PED_EN
    walk_entry_s = 1'b0;
`endif
    case (state_r)
      ST_GREEN: begin
        if ((cnt_r == '0) && (dir != DIR_BAD) && (dir != cur_r)) begin
          state_s = ST_YELLOW;
          cnt_s   = YEL_LD;
        end else begin
          state_s = ST_GREEN;
        end
      end
      ST_YELLOW: begin
        // dir is deliberately ignored: a started change cannot be cancelled.
        if (cnt_r == '0) begin
          state_s = ST_ALLRED;
          cnt_s   = RED_LD;
        end else begin
          state_s = ST_YELLOW;
        end
      end
      ST_ALLRED: begin
        if (cnt_r == '0) begin
`ifdef TLC_PED_EN
          if (pend_r) begin
            state_s      = ST_WALK;
            cnt_s        = PED_LD;
            walk_entry_s = 1'b1;
          end else begin
            state_s = ST_GREEN;
            cnt_s   = GREEN_LD;
            cur_s   = (dir == DIR_BAD) ? DIR_NS : dir;
          end
`else
          state_s = ST_GREEN;
          cnt_s   = GREEN_LD;
          cur_s   = (dir == DIR_BAD) ? DIR_NS : dir;
`endif
        end else begin
          state_s = ST_ALLRED;
        end
      end
`ifdef TLC_PED_EN
      ST_WALK: begin
        if (cnt_r == '0) begin
          state_s = ST_GREEN;
          cnt_s   = GREEN_LD;
          cur_s   = (dir == DIR_BAD) ? DIR_NS : dir;
        end else begin
          state_s = ST_WALK;
        end
      end
`endif
      default: begin
        state_s = ST_GREEN;
        cnt_s   = GREEN_LD;
        cur_s   = DIR_NS;
      end
    endcase
`ifdef TLC_PED_EN
    // A request in the same cycle as walk entry survives for the next sequence.
    pend_s = (pend_r && !walk_entry_s) || ped_req;
`endif
  end

  // Phase registers plus outputs registered from the next-state decode, so the
  // outputs always reflect the current registers with no path from dir.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= ST_GREEN;
      cnt_r    <= GREEN_LD;
      cur_r    <= DIR_NS;
      ok       <= 1'b0;
      light_ns <= LAMP_G;
      light_ew <= LAMP_R;
      light_lt <= LAMP_R;
`ifdef TLC_PED_EN
      pend_r   <= 1'b0;
      walk     <= 1'b0;
`endif
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      cur_r    <= cur_s;
      ok       <= (state_s == ST_GREEN) && (cnt_s == '0);
      {light_ns, light_ew, light_lt} <= lamps(state_s, cur_s);
`ifdef TLC_PED_EN
      pend_r   <= pend_s;
      walk     <= (state_s == ST_WALK);
`endif
    end
  end

endmodule

// File: tb/tb_tlc_light_slave.sv
// -----------------------------------------------------------------------------
// tb_tlc_light_slave
// Directed self-checking bench for tlc_light_slave with default parameters
// (GREEN_MIN=4, YEL_CYC=3, RED_CYC=2, PED_CYC=6). Observed vector is
// {ok, light_ns, light_ew, light_lt}; inputs change and outputs are sampled
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_tlc_light_slave;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  localparam logic [9:0] NS_G0 = {1'b0, G, R, R};
  localparam logic [9:0] NS_G1 = {1'b1, G, R, R};
  localparam logic [9:0] NS_Y  = {1'b0, Y, R, R};
  localparam logic [9:0] EW_G0 = {1'b0, R, G, R};
  localparam logic [9:0] EW_G1 = {1'b1, R, G, R};
  localparam logic [9:0] EW_Y  = {1'b0, R, Y, R};
  localparam logic [9:0] LT_G0 = {1'b0, R, R, G};
  localparam logic [9:0] LT_G1 = {1'b1, R, R, G};
  localparam logic [9:0] LT_Y  = {1'b0, R, R, Y};
  localparam logic [9:0] ALL_R = {1'b0, R, R, R};

  logic       clk;
  logic       rst;
  logic [1:0] dir;
  logic       ok;
  logic [2:0] light_ns;
  logic [2:0] light_ew;
  logic [2:0] light_lt;
`ifdef TLC_PED_EN
  logic       ped_req;
  logic       walk;
`endif

  int errors;
  int checks;

  tlc_light_slave dut (
    .clk      (clk),
    .rst      (rst),
    .dir      (dir),
`ifdef TLC_PED_EN
    .ped_req  (ped_req),
    .walk     (walk),
`endif
    .ok       (ok),
    .light_ns (light_ns),
    .light_ew (light_ew),
    .light_lt (light_lt)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    logic [9:0] exp_v [4];
    exp_v = '{NS_G0, NS_G0, NS_G1, NS_G1};
    rst = 1'b0;
    dir = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ok, light_ns, light_ew, light_lt} !== NS_G0) begin
      errors++;
      $display("FAIL reset_hold: got %b expected %b", {ok, light_ns, light_ew, light_lt}, NS_G0);
    end
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({ok, light_ns, light_ew, light_lt} !== exp_v[i]) begin
        errors++;
        $display("FAIL reset_release[%0d]: got %b expected %b", i, {ok, light_ns, light_ew, light_lt}, exp_v[i]);
      end
    end
  endtask

  task automatic test_change();
    logic [9:0] exp_v [9];
    exp_v = '{NS_Y, NS_Y, NS_Y, ALL_R, ALL_R, EW_G0, EW_G0, EW_G0, EW_G1};
    dir = 2'b01;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if ({ok, light_ns, light_ew, light_lt} !== exp_v[i]) begin
        errors++;
        $display("FAIL change_ns_ew[%0d]: got %b expected %b", i, {ok, light_ns, light_ew, light_lt}, exp_v[i]);
      end
    end
  endtask

  task automatic test_hold_min();
    logic [9:0] exp_v [18];
    exp_v = '{EW_Y, EW_Y, EW_Y, ALL_R, ALL_R, NS_G0, NS_G0, NS_G0, NS_G1,
              NS_Y, NS_Y, NS_Y, ALL_R, ALL_R, LT_G0, LT_G0, LT_G0, LT_G1};
    dir = 2'b00;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      checks++;
      if ({ok, light_ns, light_ew, light_lt} !== exp_v[i]) begin
        errors++;
        $display("FAIL hold_min[%0d]: got %b expected %b", i, {ok, light_ns, light_ew, light_lt}, exp_v[i]);
      end
      // Early request one cycle into the new NS green.
      if (i == 5) dir = 2'b10;
    end
  endtask

  task automatic test_invalid_dir();
    logic [9:0] exp_v [10];
    exp_v = '{LT_Y, LT_Y, LT_Y, ALL_R, ALL_R, NS_G0, NS_G0, NS_G0, NS_G1, NS_G1};
    dir = 2'b11;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({ok, light_ns, light_ew, light_lt} !== LT_G1) begin
        errors++;
        $display("FAIL invalid_hold[%0d]: got %b expected %b", i, {ok, light_ns, light_ew, light_lt}, LT_G1);
      end
    end
    dir = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if ({ok, light_ns, light_ew, light_lt} !== exp_v[i]) begin
        errors++;
        $display("FAIL invalid_grant[%0d]: got %b expected %b", i, {ok, light_ns, light_ew, light_lt}, exp_v[i]);
      end
      if (i == 0) dir = 2'b11;
    end
  endtask

  task automatic test_return_same();
    logic [9:0] exp_v [9];
    exp_v = '{NS_Y, NS_Y, NS_Y, ALL_R, ALL_R, NS_G0, NS_G0, NS_G0, NS_G1};
    dir = 2'b01;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if ({ok, light_ns, light_ew, light_lt} !== exp_v[i]) begin
        errors++;
        $display("FAIL return_same[%0d]: got %b expected %b", i, {ok, light_ns, light_ew, light_lt}, exp_v[i]);
      end
      if (i == 0) dir = 2'b00;
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] exp_v [4];
    exp_v = '{NS_G0, NS_G0, NS_G1, NS_G1};
    dir = 2'b01;
    repeat (9) @(negedge clk);
    checks++;
    if ({ok, light_ns, light_ew, light_lt} !== EW_G1) begin
      errors++;
      $display("FAIL areset_setup: got %b expected %b", {ok, light_ns, light_ew, light_lt}, EW_G1);
    end
    dir = 2'b00;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({ok, light_ns, light_ew, light_lt} !== EW_Y) begin
      errors++;
      $display("FAIL areset_yellow: got %b expected %b", {ok, light_ns, light_ew, light_lt}, EW_Y);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ok, light_ns, light_ew, light_lt} !== NS_G0) begin
      errors++;
      $display("FAIL areset_immediate: got %b expected %b", {ok, light_ns, light_ew, light_lt}, NS_G0);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({ok, light_ns, light_ew, light_lt} !== exp_v[i]) begin
        errors++;
        $display("FAIL areset_release[%0d]: got %b expected %b", i, {ok, light_ns, light_ew, light_lt}, exp_v[i]);
      end
    end
  endtask

`ifdef TLC_PED_EN
  task automatic test_ped();
    logic [9:0] exp_v [15];
    logic       exp_walk;
    exp_v = '{NS_Y, NS_Y, NS_Y, ALL_R, ALL_R, ALL_R, ALL_R, ALL_R, ALL_R,
              ALL_R, ALL_R, EW_G0, EW_G0, EW_G0, EW_G1};
    ped_req = 1'b1;
    @(negedge clk);
    ped_req = 1'b0;
    dir = 2'b01;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      exp_walk = (i >= 5) && (i <= 10);
      checks++;
      if ({walk, ok, light_ns, light_ew, light_lt} !== {exp_walk, exp_v[i]}) begin
        errors++;
        $display("FAIL ped_walk[%0d]: got walk=%b %b expected walk=%b %b", i, walk,
                 {ok, light_ns, light_ew, light_lt}, exp_walk, exp_v[i]);
      end
    end
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b0;
    dir    = 2'b00;
`ifdef TLC_PED_EN
    ped_req = 1'b0;
`endif
    test_reset();
    test_change();
    test_hold_min();
    test_invalid_dir();
    test_return_same();
    test_async_reset();
`ifdef TLC_PED_EN
    test_ped();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
